// File: rtl/fpgaol_pkg.sv
// +----------------------------------------------------------------------+
// | fpgaol_pkg : board constants and arbiter state encoding              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package fpgaol_pkg;

  localparam int LED_WIDTH = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick : combinational round-robin picker, first eligible at/after  |
// | ptr (wrapping), one-hot result. Rev 1.0                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  input  logic [NREQ-1:0]  excl,
  output logic [NREQ-1:0]  pick,
  output logic             valid
);

  logic [NREQ-1:0] cand;

  assign cand = req & ~excl;

  always_comb begin
    int idx;
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!valid && cand[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_arbiter.sv
// +----------------------------------------------------------------------+
// | led_arbiter : time-sliced round-robin owner of the board LED bus     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module led_arbiter
  import fpgaol_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int WIDTH        = LED_WIDTH,
  parameter int DWELL_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  data,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic [WIDTH-1:0]       led
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  logic [0:0]      state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   ptr_after;
  logic [IW-1:0]   pick_ptr;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] pick_excl;
  logic [NREQ-1:0] pick;
  logic            pick_valid;
  logic            grant_end;
  logic [WIDTH-1:0] led_nxt;

  always_comb begin
    owner   = '0;
    led_nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        owner   = IW'(i);
        led_nxt = led_nxt | data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign ptr_after = (owner == IW'(NREQ-1)) ? '0 : owner + 1'b1;

  // In HOLD the picker searches from the slot after the owner so handover is round-robin.
  assign pick_ptr  = (state == ST_IDLE) ? ptr : ptr_after;
  assign pick_excl = (state == ST_IDLE) ? '0  : grant;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (IW)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .excl  (pick_excl),
    .pick  (pick),
    .valid (pick_valid)
  );

  assign grant_end = (state == ST_HOLD) &&
                     (((req & grant) == '0) || (cnt == CW'(DWELL_CYCLES-1)));

  assign busy = (state == ST_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      grant <= '0;
      ptr   <= '0;
      cnt   <= '0;
      led   <= '0;
    end else begin
      led <= led_nxt;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant <= pick;
            state <= ST_HOLD;
            cnt   <= '0;
          end
        end
        ST_HOLD: begin
          if (grant_end) begin
            ptr <= ptr_after;
            cnt <= '0;
            if (pick_valid) begin
              grant <= pick;
            end else if ((req & grant) == '0) begin
              grant <= '0;
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_led_arbiter : randomized bench with a transaction-level model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_led_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int DW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   grant;
  logic           busy;
  logic [W-1:0]   led;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: owner index (-1 idle), next-priority index, cycles held so far.
  int       m_owner = -1;
  int       m_ptr   = 0;
  int       m_len   = 0;
  logic [7:0] m_led = '0;

  led_arbiter #(.NREQ(N), .WIDTH(W), .DWELL_CYCLES(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .data  (data),
    .grant (grant),
    .busy  (busy),
    .led   (led)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] m_grant();
    return (m_owner < 0) ? '0 : N'(1 << m_owner);
  endfunction

  function automatic logic [N+W:0] m_out();
    return {m_grant(), (m_owner >= 0), m_led};
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_len = 0; m_led = '0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic [N*W-1:0] d);
    logic [7:0] nl;
    int nxt;
    nl = (m_owner >= 0) ? d[m_owner*W +: W] : 8'h00;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && r[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N; m_len = 1;
        end
    end else if (!r[m_owner] || m_len == DW) begin
      m_ptr = (m_owner + 1) % N;
      nxt = -1;
      for (int k = 1; k < N; k++)
        if (nxt < 0 && r[(m_owner + k) % N]) nxt = (m_owner + k) % N;
      if (nxt >= 0) begin
        m_owner = nxt; m_len = 1;
      end else if (r[m_owner]) begin
        m_len = 1;
      end else begin
        m_owner = -1; m_len = 0;
      end
    end else begin
      m_len++;
    end
    m_led = nl;
  endfunction

  // Called at a negedge; returns at the following negedge with the model advanced.
  task automatic tick(input logic [N-1:0] r, input logic [N*W-1:0] d);
    req = r; data = d;
    @(posedge clk);
    model_step(r, d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0;
    @(negedge clk);
    n_checks++;
    if ({grant, busy, led} !== '0)
      $display("FAIL reset_state: got grant=%b busy=%b led=%h, want all zero", grant, busy, led);
    else n_pass++;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 20; c++) begin
      tick('0, 32'($urandom));
      n_checks++;
      if ({grant, busy, led} !== {4'b0000, 1'b0, 8'h00})
        $display("FAIL idle_cycle%0d: got grant=%b busy=%b led=%h, want 0/0/00", c, grant, busy, led);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    logic [N*W-1:0] d;
    d = {8'h11, 8'hA5, 8'h22, 8'h33};
    tick(4'b0100, d);
    n_checks++;
    if ({grant, busy, led} !== {4'b0100, 1'b1, 8'h00} || m_out() !== {grant, busy, led})
      $display("FAIL single_grant: got grant=%b busy=%b led=%h, want 0100/1/00", grant, busy, led);
    else n_pass++;
    tick(4'b0100, d);
    n_checks++;
    if ({grant, busy, led} !== {4'b0100, 1'b1, 8'hA5})
      $display("FAIL single_led: got grant=%b busy=%b led=%h, want 0100/1/a5", grant, busy, led);
    else n_pass++;
    tick(4'b0000, d);
    n_checks++;
    if ({grant, busy, led} !== {4'b0000, 1'b0, 8'hA5})
      $display("FAIL single_release: got grant=%b busy=%b led=%h, want 0000/0/a5", grant, busy, led);
    else n_pass++;
    tick(4'b0000, d);
    n_checks++;
    if ({grant, busy, led} !== {4'b0000, 1'b0, 8'h00})
      $display("FAIL single_idle_led: got grant=%b busy=%b led=%h, want 0000/0/00", grant, busy, led);
    else n_pass++;
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_g;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick(4'b1111, 32'($urandom));
      exp_g = 4'b0001 << ((c / DW) % N);
      n_checks++;
      if (grant !== exp_g || {grant, busy, led} !== m_out())
        $display("FAIL fairness_cycle%0d: got grant=%b busy=%b led=%h, want grant=%b model=%h",
                 c, grant, busy, led, exp_g, m_out());
      else n_pass++;
    end
  endtask

  task automatic test_early_release();
    do_reset();
    tick(4'b1010, 32'($urandom));
    tick(4'b1010, 32'($urandom));
    n_checks++;
    if (grant !== 4'b0010)
      $display("FAIL early_first_owner: got grant=%b, want 0010", grant);
    else n_pass++;
    tick(4'b1000, 32'($urandom));
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (grant !== ((c < DW) ? 4'b1000 : 4'b0001) || {grant, busy, led} !== m_out())
        $display("FAIL early_dwell%0d: got grant=%b led=%h, want grant=%b led=%h",
                 c, grant, led, (c < DW) ? 4'b1000 : 4'b0001, m_led);
      else n_pass++;
      tick(4'b1001, 32'($urandom));
    end
  endtask

  task automatic test_sole_timeout();
    do_reset();
    for (int c = 0; c < 15; c++) begin
      tick(4'b0001, 32'($urandom));
      n_checks++;
      if (grant !== 4'b0001 || busy !== 1'b1 || led !== m_led)
        $display("FAIL sole_cycle%0d: got grant=%b busy=%b led=%h, want 0001/1/%h", c, grant, busy, led, m_led);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) tick(4'b0110, 32'($urandom));
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({grant, busy, led} !== '0)
      $display("FAIL async_reset: got grant=%b busy=%b led=%h, want all zero", grant, busy, led);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick(4'b1010, 32'($urandom));
    n_checks++;
    if (grant !== 4'b0010 || busy !== 1'b1)
      $display("FAIL after_reset_grant: got grant=%b busy=%b, want 0010/1", grant, busy);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    do_reset();
    r = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
      tick(r, 32'($urandom));
      n_checks++;
      if ({grant, busy, led} !== m_out() || !$onehot0(grant))
        $display("FAIL random_cycle%0d: got grant=%b busy=%b led=%h, want %h", c, grant, busy, led, m_out());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_early_release();
    test_sole_timeout();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
